// File: rtl/unary_binary_mac_lanes.sv
// Multi-lane unary-binary MAC: out_i = a_i*b_i + c_i (+ previous out_i when accum).
// Optional macro UB_MAC_EARLY_TERM_EN ends the unary run at max(a) instead of 2^W-1 cycles.
module unary_binary_mac_lanes #(
  parameter int unsigned W     = 4,
  parameter int unsigned LANES = 4,
  parameter int unsigned G     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          accum,
  input  logic [LANES*W-1:0]            a,
  input  logic [LANES*W-1:0]            b,
  input  logic [LANES*W-1:0]            c,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*(2*W+G)-1:0]      out
);

  localparam int unsigned OW = 2*W + G;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [W-1:0]              cnt_q, cnt_d;
  logic [LANES*W-1:0]        a_q, a_d;
  logic [LANES*W-1:0]        b_q, b_d;
  logic [LANES-1:0][OW-1:0]  acc_q, acc_d;
  logic                      accept_c;
  logic                      last_cnt_c;

  assign accept_c = (state_q == IDLE) && in_valid;

`ifdef UB_MAC_EARLY_TERM_EN
  logic [W-1:0] max_q, max_d;
  logic [W-1:0] max_a_c;

  // Largest unary operand over all lanes of the incoming operand set.
  always_comb begin
    max_a_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (a[i*W +: W] > max_a_c) max_a_c = a[i*W +: W];
    end
  end

  assign max_d      = accept_c ? max_a_c : max_q;
  assign last_cnt_c = (cnt_q == max_q - W'(1));
`else
  localparam logic [W-1:0] LAST_CNT = W'((1 << W) - 2);
  assign last_cnt_c = (cnt_q == LAST_CNT);
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
`ifdef UB_MAC_EARLY_TERM_EN
      max_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
`ifdef UB_MAC_EARLY_TERM_EN
      max_q   <= max_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef UB_MAC_EARLY_TERM_EN
          state_d = (max_a_c == '0) ? DONE : RUN;
`else
          state_d = RUN;
`endif
        end
      end
      RUN:     if (last_cnt_c) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and per-lane unary accumulation.
  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (accept_c) begin
      cnt_d = '0;
      a_d   = a;
      b_d   = b;
      for (int i = 0; i < int'(LANES); i++) begin
        acc_d[i] = OW'(c[i*W +: W]) + (accum ? acc_q[i] : OW'(0));
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + W'(1);
      for (int i = 0; i < int'(LANES); i++) begin
        if (cnt_q < a_q[i*W +: W]) acc_d[i] = acc_q[i] + OW'(b_q[i*W +: W]);
      end
    end
  end

  // Outputs come straight from registered state and accumulators.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out       = acc_q;
  end

endmodule

// File: tb/tb_unary_binary_mac_lanes.sv
// Scoreboard bench for unary_binary_mac_lanes: driver queues expected results, negedge monitor checks them.
module tb_unary_binary_mac_lanes;

  localparam int unsigned W     = 4;
  localparam int unsigned LANES = 4;
  localparam int unsigned G     = 2;
  localparam int unsigned OW    = 2*W + G;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic                   accum;
  logic [LANES*W-1:0]     a, b, c;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OW-1:0]    out;

  unary_binary_mac_lanes #(.W(W), .LANES(LANES), .G(G)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .accum(accum), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*OW-1:0] o;
    int                  lat;
    int                  acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  function automatic logic [LANES*W-1:0] p4(input int x0, input int x1, input int x2, input int x3);
    return {4'(x3), 4'(x2), 4'(x1), 4'(x0)};
  endfunction

  function automatic logic [LANES*OW-1:0] po(input int x0, input int x1, input int x2, input int x3);
    return {10'(x3), 10'(x2), 10'(x1), 10'(x0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: first DONE cycle pops the scoreboard; held DONE cycles must be stable.
  logic                prev_v = 1'b0;
  logic [LANES*OW-1:0] held   = '0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("result", 64'(out), 64'(e.o));
        chk("latency", 64'(edge_cnt - e.acc_edge), 64'(e.lat));
      end
      held = out;
    end else if (out_valid) begin
      chk("held_out_stable", 64'(out), 64'(held));
      chk("held_in_ready_low", 64'(in_ready), 64'(0));
    end
    prev_v = out_valid;
  end

  // Issue one operand set and queue its expected result and latency.
  task automatic send(input logic [LANES*W-1:0] ta, input logic [LANES*W-1:0] tb,
                      input logic [LANES*W-1:0] tc, input logic tacc,
                      input logic [LANES*OW-1:0] eo, input int elat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(0), 64'(1));
    a = ta; b = tb; c = tc; accum = tacc; in_valid = 1'b1;
    e.o = eo; e.lat = elat; e.acc_edge = edge_cnt + 1;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    a = '0; b = '0; c = '0; accum = 1'b0;
  endtask

  // Wait (bounded) for the DONE handshake to complete.
  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'(0), 64'(1));
    while (!out_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  function automatic int lat_of(input logic [LANES*W-1:0] ta);
`ifdef UB_MAC_EARLY_TERM_EN
    int m = 0;
    for (int i = 0; i < int'(LANES); i++) if (int'(ta[i*W +: W]) > m) m = int'(ta[i*W +: W]);
    return (m == 0) ? 1 : m;
`else
    return (1 << W) - 1;
`endif
  endfunction

  initial begin
    logic [LANES*W-1:0] full, mix_a;
    logic [LANES*OW-1:0] mix_o;
    full = p4(15, 15, 15, 15);
    reset = 1'b1; in_valid = 1'b0; accum = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out", 64'(out), 64'(0));

    // Full-scale operands.
    send(full, full, full, 1'b0, po(240, 240, 240, 240), lat_of(full));
    wait_done();

    // Mixed lanes.
`ifdef UB_MAC_EARLY_TERM_EN
    mix_a = p4(0, 1, 7, 2);  mix_o = po(1, 3, 19, 2);
`else
    mix_a = p4(0, 1, 7, 15); mix_o = po(1, 3, 19, 15);
`endif
    send(mix_a, p4(15, 3, 2, 1), p4(1, 0, 5, 0), 1'b0, mix_o, lat_of(mix_a));
    wait_done();

    // Chaining through the accumulator, wrapping modulo 1024.
    send(full, full, full, 1'b0, po(240, 240, 240, 240), lat_of(full));
    wait_done();
    send(full, full, full, 1'b1, po(480, 480, 480, 480), lat_of(full));
    wait_done();
    send(full, full, full, 1'b1, po(720, 720, 720, 720), lat_of(full));
    wait_done();
    send(full, full, full, 1'b1, po(960, 960, 960, 960), lat_of(full));
    wait_done();
    send(full, full, full, 1'b1, po(176, 176, 176, 176), lat_of(full));
    wait_done();

    // Backpressure with in_valid held high.
    out_ready = 1'b0;
    send(p4(3, 2, 1, 0), p4(4, 5, 6, 7), p4(1, 2, 3, 4), 1'b0, po(13, 12, 9, 4), lat_of(p4(3, 2, 1, 0)));
    in_valid = 1'b1; a = full; b = full; c = full;
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'(1));
    chk("release_out_valid", 64'(out_valid), 64'(0));
    chk("release_out_kept", 64'(out), 64'(po(13, 12, 9, 4)));

    // Reset mid-RUN at counter 5 (default timing; long run in both builds).
    send(full, full, full, 1'b0, po(240, 240, 240, 240), lat_of(full));
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_back());
    chk("midrun_reset_out_valid", 64'(out_valid), 64'(0));
    chk("midrun_reset_in_ready", 64'(in_ready), 64'(1));
    chk("midrun_reset_out", 64'(out), 64'(0));
    send(p4(2, 2, 2, 2), p4(3, 3, 3, 3), p4(4, 4, 4, 4), 1'b1, po(10, 10, 10, 10), lat_of(p4(2, 2, 2, 2)));
    wait_done();

    // Zero unary operands.
    send(p4(0, 0, 0, 0), p4(5, 5, 5, 5), p4(9, 8, 7, 6), 1'b0, po(9, 8, 7, 6), lat_of(p4(0, 0, 0, 0)));
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unary_binary_mac_lanes.md
# unary_binary_mac_lanes

Multi-lane, parametrised unary-binary multiply-accumulate engine computing out = a*b + c (optionally plus the previous result) per lane. Operand `a` is consumed as a unary stream: a shared counter is compared against it, and `b` is added once for every cycle in which the counter is below `a`. This is the next generation of the single-lane 4-bit unary-binary MAC. It adds lane count, operand width, guard bits, valid/ready backpressure on both sides, and result chaining, and it sits between the operand staging buffer and the result collector.

## Interface
- `W`, 4, operand width of a, b and c.
- `LANES`, 4, number of parallel MAC lanes sharing one counter and one FSM.
- `G`, 2, accumulator guard bits; output width OW = 2*W + G.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  operand set present.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `accum`  in  1  when 1, the accumulator starts at c plus the previous lane result instead of c.
- `a`  in  LANES*W  unary operands; lane i occupies bits [i*W +: W].
- `b`  in  LANES*W  binary operands, packed the same way.
- `c`  in  LANES*W  addends, zero-extended to OW.
- `out_valid`  out  1  results valid.
- `out_ready`  in  1  consumer accepts the results.
- `out`  out  LANES*OW  results; lane i occupies bits [i*OW +: OW].

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: accept on `in_valid && in_ready`.
  - Register a and b.
  - Set acc_i <= zext(c_i) + (accum ? acc_i : 0).
  - Set counter <= 0.
  - Next state is RUN; in the early-termination build, next state is DONE when max(a) == 0.
- RUN, each cycle:
  - Every lane with counter < a_i does acc_i <= acc_i + b_i.
  - counter <= counter + 1.
  - Exit to DONE on the last compute cycle (see Timing).
- DONE:
  - `out_valid` = 1 and `out` = acc.
  - Both are held stable until `out_ready` = 1.
  - On that edge the FSM returns to IDLE. acc is not cleared, so it remains available to a following `accum` transaction.
- Arithmetic: all adds are modulo 2^OW, with no saturation and no overflow flag. Without `accum` the result always fits in OW bits when G >= 1.
- `in_valid` is ignored outside IDLE. Operand inputs are sampled only on the accept edge.

## Timing
- Reset values:
  - state = IDLE, counter = 0, acc = 0.
  - `in_ready` = 1, `out_valid` = 0, `out` = 0.
- Reset asserted in any state aborts the operation. All of the reset values apply on the next cycle, and a later `accum` transaction sees a previous result of 0.
- Default build:
  - RUN lasts exactly 2^W - 1 cycles (counter 0 .. 2^W-2), independent of the operand values.
  - `out_valid` rises 2^W - 1 edges after the accept edge. For W = 4 this is 15 edges.
- Throughput: the next accept is possible on the edge after the DONE handshake. There is no overlap of transactions.
- `out_ready` held high during RUN has no effect.
- Simultaneous `reset` and a DONE handshake: reset wins.

## Configuration
- `UB_MAC_EARLY_TERM_EN`, when defined:
  - RUN ends once counter reaches max over lanes of a_i, so RUN lasts max(a) cycles.
  - If max(a) == 0, the accept edge goes directly to DONE and `out_valid` = 1 in the cycle after the accept edge.
  - Results are identical to the default build; only latency changes.
- When undefined: fixed latency as given under Timing, and no max-of-a comparator is built.

## Test plan
- Full-scale operands. After reset, with W=4, LANES=4, G=2, apply a=b=c=15 on all lanes with accum=0.
  - Required: `out_valid` rises 15 edges after accept, and every lane's out = 240.
- Mixed lanes. Apply a={0,1,7,15}, b={15,3,2,1}, c={1,0,5,0}.
  - Required: out = {1,3,19,15}.
  - Early-termination build: with lane 3's a set to 2, latency is 7 edges and out = {1,3,19,2}.
- Chaining. Apply a=b=c=15 with accum=0, then four more transactions with accum=1.
  - Required: out = 240, 480, 720, 960, then 176 (1200 mod 1024).
- Backpressure. Hold `out_ready`=0 for 5 cycles after `out_valid` rises, with `in_valid`=1 throughout.
  - Required: `out` stays stable, `in_ready`=0, and no accept occurs.
  - On release, `in_ready`=1 in the following cycle.
- Reset mid-RUN. Assert reset when counter=5.
  - Required: next cycle `out_valid`=0, `in_ready`=1, `out`=0.
  - A following accum=1 transaction with a=2, b=3, c=4 yields 10.
- Zero operands, early-termination build. Apply a=0 on all lanes with c={9,8,7,6}.
  - Required: `out_valid`=1 in the cycle after accept, out = {9,8,7,6}.
  - Default build: same results after 15 edges.
